// File: rtl/regfile_pkg.sv
// Shared types and defaults for the scoreboarded register file.
// No logic: enum for the clear engine plus default geometry.
// Nothing here carries flow control.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } clr_state_e;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits with reserve gating and sweep clearing.
// Pending bits update at the clock edge; reserve_rdy is combinational.
// Reserves are accepted only when reserve_rdy is high; others are dropped.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  idle,
    input  logic                  wr_vld,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic                  rsv_vld,
    input  logic [ADDR_W-1:0]     rsv_addr,
    input  logic                  sweep_vld,
    input  logic [ADDR_W-1:0]     sweep_addr,
    output logic [2**ADDR_W-1:0]  pending_q,
    output logic                  reserve_rdy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] pending_d;
    logic             rsv_zero;

    // A reservation is acceptable when the target is free or is being retired by a write this cycle.
    always_comb begin
        rsv_zero    = (ZERO_REG != 0) && (rsv_addr == '0);
        reserve_rdy = idle && !rsv_zero &&
                      (!pending_q[rsv_addr] || (wr_vld && (wr_addr == rsv_addr)));
    end

    // Writeback clears, a new reservation sets afterwards so the newest producer wins; sweep clears one slot.
    always_comb begin
        pending_d = pending_q;
        if (sweep_vld) begin
            pending_d[sweep_addr] = 1'b0;
        end else begin
            if (wr_vld) begin
                pending_d[wr_addr] = 1'b0;
            end
            if (rsv_vld && reserve_rdy) begin
                pending_d[rsv_addr] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            pending_d[0] = 1'b0;
        end
    end

    // Pending-bit storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule : regfile_scoreboard

// File: rtl/regfile_sb.sv
// Register file with scoreboard, write-to-read forwarding and a bulk-clear sweep.
// Reads are combinational (same-cycle forwarding); writes land at the edge; sweep takes DEPTH cycles.
// During a sweep writes and reserves are ignored and all valids/reserve_ready read low.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              ctrl_writeEnable,
    input  logic [ADDR_W-1:0] ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB,
    output logic              valid_readRegA,
    output logic              valid_readRegB,
    input  logic              ctrl_reserve,
    input  logic [ADDR_W-1:0] ctrl_reserveReg,
    output logic              reserve_ready,
    input  logic              ctrl_clear,
    output logic              clear_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic              idle;
    logic              sweep;
    logic              wr_vld;
    logic              fwd_a;
    logic              fwd_b;

    // Qualify the write strobe: only in IDLE and never to a hardwired-zero register.
    always_comb begin
        idle   = (state_q == IDLE);
        sweep  = (state_q == SWEEP);
        wr_vld = idle && ctrl_writeEnable &&
                 !((ZERO_REG != 0) && (ctrl_writeReg == '0));
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clock),
        .rst_n       (ctrl_reset),
        .idle        (idle),
        .wr_vld      (wr_vld),
        .wr_addr     (ctrl_writeReg),
        .rsv_vld     (ctrl_reserve),
        .rsv_addr    (ctrl_reserveReg),
        .sweep_vld   (sweep),
        .sweep_addr  (cnt_q),
        .pending_q   (pending),
        .reserve_rdy (reserve_ready)
    );

    // Read ports: forward same-cycle write data, else storage; forwarding is held off while in reset.
    always_comb begin
        fwd_a          = ctrl_reset && wr_vld && (ctrl_writeReg == ctrl_readRegA);
        fwd_b          = ctrl_reset && wr_vld && (ctrl_writeReg == ctrl_readRegB);
        data_readRegA  = fwd_a ? data_writeReg : regs_q[ctrl_readRegA];
        data_readRegB  = fwd_b ? data_writeReg : regs_q[ctrl_readRegB];
        valid_readRegA = idle && (fwd_a || !pending[ctrl_readRegA]);
        valid_readRegB = idle && (fwd_b || !pending[ctrl_readRegB]);
        clear_busy     = sweep;
    end

    // Next-state for storage and the clear engine; the sweep counter wraps to 0 after all-ones.
    always_comb begin
        regs_d  = regs_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (wr_vld) begin
                    regs_d[ctrl_writeReg] = data_writeReg;
                end
                if (ctrl_clear) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                regs_d[cnt_q] = '0;
                cnt_d         = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Storage and clear-engine registers.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            regs_q  <= regs_d;
        end
    end

endmodule : regfile_sb
